// File: rtl/delay_sched_if.sv
// Bundle of the request/grant/status signals between the requesters and delay_sched.
// The master side drives requests and lengths; the slave side (the scheduler) returns grant/status.
interface delay_sched_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 13
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [CBITS-1:0]      cnt_o;
  logic                  err;

  modport master (
    output req, len,
    input  gnt, done, busy, cnt_o, err
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, cnt_o, err
  );
endinterface

// File: rtl/delay_sched.sv
// Shared countdown timer: a round-robin arbiter grants one requester, counts its clamped length, pulses done.
// Define DELAY_SCHED_PRIO0_EN to give requester 0 fixed highest priority over the round-robin.
module delay_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 13,
  parameter int N     = 5000
) (
  input  logic         clk,
  input  logic         rst,
  delay_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] target_q, target_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic             err_q, err_d;

  logic [IW-1:0]    pick;
  logic             pick_vld;

  // Zero-length requests still take one count cycle; anything above N saturates at N.
  function automatic logic [CBITS-1:0] clamp_len(input logic [CBITS-1:0] l);
    if (l == '0) return CBITS'(1);
    if (l > CBITS'(N)) return CBITS'(N);
    return l;
  endfunction

  // Scan from the farthest slot down to ptr+1 so the nearest asserted request overwrites the rest.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
`ifdef DELAY_SCHED_PRIO0_EN
    if (bus.req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    win_d    = win_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d  = S_COUNT;
          gnt_d    = NREQ'(1) << pick;
          busy_d   = 1'b1;
          cnt_d    = CBITS'(1);
          target_d = clamp_len(bus.len[int'(pick)*CBITS +: CBITS]);
          win_d    = pick;
        end
      end

      S_COUNT: begin
        // A dropped request wins over reaching the target in the same cycle.
        if (!bus.req[win_q]) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = win_q;
        end else if (cnt_q == target_q) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        ptr_d   = win_q;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Invariants over the registered state; err follows them with one cycle of delay.
  always_comb begin
    err_d = 1'b0;
    if (cnt_q > target_q)                               err_d = 1'b1;
    if (busy_q && !$onehot(gnt_q))                      err_d = 1'b1;
    if (state_q == S_IDLE && gnt_q != '0)               err_d = 1'b1;
    if (state_q == S_DONE && done_q != gnt_q)           err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      target_q <= '0;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.cnt_o = cnt_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: latency, clamping, rotation, abort, reset abort and length sampling.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_delay_sched;

  localparam int NREQ  = 4;
  localparam int CBITS = 13;
  localparam int N     = 5000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic err_seen;

  delay_sched_if #(.NREQ(NREQ), .CBITS(CBITS)) bus ();

  delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && bus.err === 1'b1) err_seen = 1'b1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*CBITS +: CBITS] = CBITS'(v);
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int   ord [5];
    int   tim [5];
    int   nd;
    int   peak;
    int   k_done;
    logic got;
    logic oh_bad;
    logic any_done;

    checks   = 0;
    errors   = 0;
    err_seen = 1'b0;
    bus.len  = '0;
    do_reset();

    // Reset state
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cnt", 32'(bus.cnt_o), 0);
    check("rst_err", 32'(bus.err), 0);

    // Single request, len 3; len changes after the grant must not matter
    set_len(0, 3);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", 32'(bus.gnt), 1);
    check("t1_cnt1", 32'(bus.cnt_o), 1);
    check("t1_busy", 32'(bus.busy), 1);
    set_len(0, 7);
    tick();
    check("t1_cnt2", 32'(bus.cnt_o), 2);
    tick();
    check("t1_cnt3", 32'(bus.cnt_o), 3);
    check("t1_nodone", 32'(bus.done), 0);
    tick();
    check("t1_done", 32'(bus.done), 1);
    check("t1_gnt_held", 32'(bus.gnt), 1);
    check("t1_cnt_held", 32'(bus.cnt_o), 3);
    bus.req = '0;
    tick();
    check("t1_idle_gnt", 32'(bus.gnt), 0);
    check("t1_idle_done", 32'(bus.done), 0);
    check("t1_idle_busy", 32'(bus.busy), 0);
    check("t1_idle_cnt", 32'(bus.cnt_o), 0);

    // len 0 behaves as 1
    set_len(0, 0);
    bus.req = 4'b0001;
    tick();
    check("t2_cnt1", 32'(bus.cnt_o), 1);
    tick();
    check("t2_done", 32'(bus.done), 1);
    bus.req = '0;
    tick();

    // Largest representable length clamps to N
    set_len(0, 8191);
    bus.req = 4'b0001;
    got     = 1'b0;
    peak    = 0;
    k_done  = 0;
    for (int k = 1; k <= 6000 && !got; k++) begin
      tick();
      if (int'(bus.cnt_o) > peak) peak = int'(bus.cnt_o);
      if (bus.done != '0) begin
        got    = 1'b1;
        k_done = k;
      end
    end
    check("t2_clamp_seen", 32'(got), 1);
    check("t2_clamp_lat", 32'(k_done), 5001);
    check("t2_clamp_peak", 32'(peak), 5000);
    bus.req = '0;
    tick();

    // All four requesting with len 2: rotation order and a grant period of target+2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    bus.req = 4'b1111;
    nd      = 0;
    oh_bad  = 1'b0;
    for (int k = 1; k <= 60 && nd < 5; k++) begin
      tick();
      if (bus.busy && !$onehot(bus.gnt)) oh_bad = 1'b1;
      if (bus.done != '0) begin
        ord[nd] = oh_idx(bus.done);
        tim[nd] = k;
        nd++;
      end
    end
    check("t3_ndone", 32'(nd), 5);
    check("t3_onehot", 32'(oh_bad), 0);
    check("t3_first_t", 32'(tim[0]), 3);
    for (int i = 0; i < 5; i++) begin
`ifdef DELAY_SCHED_PRIO0_EN
      check($sformatf("t3_order%0d", i), 32'(ord[i]), 0);
`else
      check($sformatf("t3_order%0d", i), 32'(ord[i]), 32'(i % NREQ));
`endif
      if (i > 0) check($sformatf("t3_space%0d", i), 32'(tim[i] - tim[i-1]), 4);
    end
    bus.req = '0;
    tick();
    tick();

    // Abort: requester 1 drops at cnt 4, then requester 2 is granted
    do_reset();
    set_len(1, 10);
    set_len(2, 5);
    bus.req = 4'b0110;
    tick();
    check("t4_gnt1", 32'(bus.gnt), 2);
    any_done = 1'b0;
    got      = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (bus.cnt_o == CBITS'(4)) got = 1'b1;
      else begin
        tick();
        if (bus.done != '0) any_done = 1'b1;
      end
    end
    check("t4_reach4", 32'(got), 1);
    bus.req = 4'b0100;
    tick();
    check("t4_ab_gnt", 32'(bus.gnt), 0);
    check("t4_ab_busy", 32'(bus.busy), 0);
    check("t4_ab_done", 32'(bus.done | NREQ'(any_done)), 0);
    tick();
    check("t4_gnt2", 32'(bus.gnt), 4);
    check("t4_gnt2_cnt", 32'(bus.cnt_o), 1);
    bus.req = '0;
    tick();

    // Drop coinciding with cnt == target: abort wins, no done
    set_len(0, 3);
    bus.req = 4'b0001;
    tick();
    tick();
    tick();
    check("t5_cnt3", 32'(bus.cnt_o), 3);
    bus.req = '0;
    tick();
    check("t5_nodone", 32'(bus.done), 0);
    check("t5_idle", 32'(bus.busy), 0);
    tick();

    // Reset in the middle of a count
    set_len(0, 20);
    bus.req = 4'b0001;
    tick();
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (bus.cnt_o == CBITS'(7)) got = 1'b1;
      else tick();
    end
    check("t6_reach7", 32'(got), 1);
    rst = 1'b1;
    tick();
    check("t6_gnt", 32'(bus.gnt), 0);
    check("t6_done", 32'(bus.done), 0);
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_cnt", 32'(bus.cnt_o), 0);
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    bus.req = 4'b1111;
    rst     = 1'b0;
    tick();
    check("t6_regnt", 32'(bus.gnt), 1);
    check("t6_recnt", 32'(bus.cnt_o), 1);
    bus.req = '0;
    tick();
    tick();

    check("err_never", 32'(err_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
